sram_rw0_req_driver: RTL and testbench



---
 rtl/sram_rw0_req_driver_if.sv | 38 +++
 rtl/sram_rw0_req_driver.sv | 166 ++++++++++++++++
 tb/tb_sram_rw0_req_driver.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rw0_req_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_rw0_req_driver_if
// Purpose  : Client-side request/response bundle for sram_rw0_req_driver.
//            Requests use a valid/ready handshake; read responses return
//            in request order through their own valid/ready handshake.
// Signals  : req_valid/req_ready/req_write/req_addr/req_wdata/req_wmask
//            (client -> driver request), resp_valid/resp_ready/resp_rdata
//            (driver -> client read data).
// Modports : master = client pipeline, slave = sram_rw0_req_driver.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_rw0_req_driver_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 2848,
    parameter int MASK_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_rw0_req_driver.sv
`default_nettype none
// ============================================================================
// Module   : sram_rw0_req_driver
// Purpose  : Initiator-side controller for a single-port RW0 SRAM wrapper.
//            Accepted client requests drive the RW0 port combinationally in
//            the accept cycle; read data arrives one cycle later and is either
//            bypassed straight to the client or parked in a small response
//            buffer. Request credit (buffer count + in-flight read) keeps the
//            buffer from ever overflowing.
// Ports    : clock, reset           - single clock, synchronous active-high reset
//            client (slave modport) - request / read-response handshakes
//            init_busy              - power-up zero sweep in progress
//            RW0_*                  - array port (RW0_rdata valid the cycle
//                                     after a read access)
// Options  : SRAM_INIT_SWEEP_EN     - when defined, every reset is followed by
//                                     a 2^ADDR_W-cycle sweep writing zero to
//                                     the whole array before requests are taken.
// Revision : 1.0 - initial release
// ============================================================================
module sram_rw0_req_driver #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 2848,
    parameter int MASK_W     = 8,
    parameter int RESP_DEPTH = 2
) (
    input  wire                  clock,
    input  wire                  reset,
    sram_rw0_req_driver_if.slave client,
    output logic                 init_busy,
    output logic                 RW0_clk,
    output logic                 RW0_en,
    output logic                 RW0_wmode,
    output logic [ADDR_W-1:0]    RW0_addr,
    output logic [DATA_W-1:0]    RW0_wdata,
    output logic [MASK_W-1:0]    RW0_wmask,
    input  wire  [DATA_W-1:0]    RW0_rdata
);

    localparam int c_cnt_w = $clog2(RESP_DEPTH + 1);
    localparam int c_ptr_w = $clog2(RESP_DEPTH);
    localparam logic [c_cnt_w:0]   c_depth    = (c_cnt_w + 1)'(RESP_DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(RESP_DEPTH - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               r_rd_pend;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [DATA_W-1:0]  r_buf [RESP_DEPTH];

    logic               w_run;
    logic               w_init;
    logic [ADDR_W-1:0]  w_init_addr;
    logic               w_fire;
    logic               w_buf_empty;
    logic               w_push;
    logic               w_pop_buf;
    logic [c_cnt_w:0]   w_used;

    function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Init sweep state machine (only present when the option is compiled in)
    // ------------------------------------------------------------------------
`ifdef SRAM_INIT_SWEEP_EN
    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_init = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_init_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_st_init;
            r_init_addr <= '0;
        end else if (r_state == c_st_init) begin
            r_init_addr <= r_init_addr + ADDR_W'(1);
            if (r_init_addr == '1) begin
                r_state <= c_st_run;
            end
        end
    end

    assign w_init      = !reset && (r_state == c_st_init);
    assign w_run       = (r_state == c_st_run);
    assign w_init_addr = r_init_addr;
`else
    assign w_init      = 1'b0;
    assign w_run       = 1'b1;
    assign w_init_addr = '0;
`endif

    assign init_busy = w_init;

    // ------------------------------------------------------------------------
    // Request credit and response path
    // ------------------------------------------------------------------------
    // Every accepted read eventually needs a buffer slot, so the in-flight
    // read counts against the free space as if it had already landed.
    assign w_used       = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_rd_pend};
    assign w_buf_empty  = (r_count == '0);

    assign client.req_ready  = !reset && w_run && (w_used < c_depth);
    assign w_fire            = client.req_valid && client.req_ready;

    assign client.resp_valid = !reset && (!w_buf_empty || r_rd_pend);
    // Empty buffer means the only candidate is the array data arriving now.
    assign client.resp_rdata = w_buf_empty ? RW0_rdata : r_buf[r_head];

    // Arriving read data is stored unless it is bypassed and taken this cycle;
    // the buffer itself only drains when it holds something.
    assign w_push    = r_rd_pend && !(w_buf_empty && client.resp_ready);
    assign w_pop_buf = client.resp_ready && !w_buf_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_rd_pend <= 1'b0;
            r_head    <= '0;
            r_tail    <= '0;
        end else begin
            r_rd_pend <= w_fire && !client.req_write;
            if (w_push) begin
                r_tail <= f_next_ptr(r_tail);
            end
            if (w_pop_buf) begin
                r_head <= f_next_ptr(r_head);
            end
            if (w_push && !w_pop_buf) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_pop_buf) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Data storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf[r_tail] <= RW0_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Array port drive
    // ------------------------------------------------------------------------
    assign RW0_clk = clock;

    always_comb begin
        RW0_en    = w_fire;
        RW0_wmode = client.req_write;
        RW0_addr  = client.req_addr;
        RW0_wdata = client.req_wdata;
        RW0_wmask = w_fire ? client.req_wmask : '0;
        if (w_init) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = w_init_addr;
            RW0_wdata = '0;
            RW0_wmask = '1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_rw0_req_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_rw0_req_driver
// Purpose  : Self-checking bench for sram_rw0_req_driver. Contains an array
//            model driven by the RW0 port and a transaction-level reference
//            (memory image plus queue of owed read responses) driven only by
//            the bench's own stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_rw0_req_driver;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 2848;
    localparam int MASK_W     = 8;
    localparam int RESP_DEPTH = 2;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int LANE       = DATA_W / MASK_W;
`ifdef SRAM_INIT_SWEEP_EN
    localparam int INIT_CYCLES = 32;
`else
    localparam int INIT_CYCLES = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_rw0_req_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) cl ();

    logic              init_busy;
    logic              RW0_clk;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [ADDR_W-1:0] RW0_addr;
    logic [DATA_W-1:0] RW0_wdata;
    logic [MASK_W-1:0] RW0_wmask;
    logic [DATA_W-1:0] RW0_rdata;

    sram_rw0_req_driver #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .client    (cl),
        .init_busy (init_busy),
        .RW0_clk   (RW0_clk),
        .RW0_en    (RW0_en),
        .RW0_wmode (RW0_wmode),
        .RW0_addr  (RW0_addr),
        .RW0_wdata (RW0_wdata),
        .RW0_wmask (RW0_wmask),
        .RW0_rdata (RW0_rdata)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d,
                                                input logic [DATA_W-1:0] new_d,
                                                input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] r;
        r = old_d;
        for (int l = 0; l < MASK_W; l++) if (m[l]) r[l*LANE +: LANE] = new_d[l*LANE +: LANE];
        return r;
    endfunction

    task automatic chkb(input string nm, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkv(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got[63:0]=%h exp[63:0]=%h t=%0t", nm, got[63:0], exp[63:0], $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Array model (environment): responds to whatever the DUT drives on RW0.
    // Read data is only meaningful the cycle after a read; otherwise noise.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] sram_mem [DEPTH];

    always @(posedge clock) begin
        if (RW0_en && !RW0_wmode) RW0_rdata <= sram_mem[RW0_addr];
        else                      RW0_rdata <= rand_word();
        if (RW0_en && RW0_wmode)  sram_mem[RW0_addr] = merge(sram_mem[RW0_addr], RW0_wdata, RW0_wmask);
    end

    // ------------------------------------------------------------------------
    // Reference: memory image and the in-order list of read data still owed
    // to the client. Up to RESP_DEPTH reads may be owed at once.
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int                init_left = 0;

    always @(posedge clock) begin
        bit m_busy, m_fire, m_pop;
        m_busy = (init_left > 0);
        m_fire = !reset && !m_busy && cl.req_valid && (exp_q.size() < RESP_DEPTH);
        m_pop  = !reset && cl.resp_ready && (exp_q.size() > 0);
        if (reset) begin
            exp_q.delete();
            init_left = INIT_CYCLES;
        end else if (m_busy) begin
            ref_mem[DEPTH - init_left] = '0;
            init_left--;
        end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_fire) begin
                if (cl.req_write) ref_mem[cl.req_addr] = merge(ref_mem[cl.req_addr], cl.req_wdata, cl.req_wmask);
                else              exp_q.push_back(ref_mem[cl.req_addr]);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Compare process: every cycle, away from the active edge.
    // ------------------------------------------------------------------------
    always @(negedge clock) begin
        bit c_busy, c_fire;
        chkb("rw0_clk", RW0_clk, 1'b0);
        if (reset) begin
            chkb("rst_req_ready", cl.req_ready, 1'b0);
            chkb("rst_resp_valid", cl.resp_valid, 1'b0);
            chkb("rst_rw0_en", RW0_en, 1'b0);
        end else begin
            c_busy = (init_left > 0);
            c_fire = !c_busy && cl.req_valid && (exp_q.size() < RESP_DEPTH);
            chkb("req_ready", cl.req_ready, !c_busy && (exp_q.size() < RESP_DEPTH));
            chkb("init_busy", init_busy, c_busy);
            chkb("resp_valid", cl.resp_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) chkd("resp_rdata", cl.resp_rdata, exp_q[0]);
            chkb("rw0_en", RW0_en, c_busy || c_fire);
            if (c_busy) begin
                chkb("init_wmode", RW0_wmode, 1'b1);
                chkv("init_addr", 32'(RW0_addr), 32'(DEPTH - init_left));
                chkv("init_wmask", 32'(RW0_wmask), 32'hFF);
                chkd("init_wdata", RW0_wdata, '0);
            end else if (c_fire) begin
                chkb("rw0_wmode", RW0_wmode, cl.req_write);
                chkv("rw0_addr", 32'(RW0_addr), 32'(cl.req_addr));
                chkv("rw0_wmask", 32'(RW0_wmask), 32'(cl.req_wmask));
                if (cl.req_write) chkd("rw0_wdata", RW0_wdata, cl.req_wdata);
            end else begin
                chkv("rw0_wmask_idle", 32'(RW0_wmask), 32'h0);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input int a,
                         input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        cl.req_valid = v;
        cl.req_write = w;
        cl.req_addr  = ADDR_W'(a);
        cl.req_wdata = d;
        cl.req_wmask = m;
    endtask

    // Called just after reset drops; returns at a negedge with the sweep done.
    task automatic wait_init();
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            if (!init_busy) break;
            n++;
            if (n > 200) break;
            @(posedge clock);
            #1;
        end
        chkv("init_cycles", 32'(n), 32'(INIT_CYCLES));
        chkb("lit_ready_after_rst", cl.req_ready, 1'b1);
        chkb("lit_valid_after_rst", cl.resp_valid, 1'b0);
    endtask

    logic [DATA_W-1:0] pat_a, pat_b, exp_ab, d0, d1, d5;

    initial begin
        pat_a = {89{32'hDEADBEEF}};
        pat_b = {89{32'h01234567}};
        for (int i = 0; i < DEPTH; i++) begin
            d0 = rand_word();
            sram_mem[i] = d0;
            ref_mem[i]  = d0;
        end
        drive(1'b0, 1'b0, 0, '0, '0);
        cl.resp_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        wait_init();
        step();

        // Full write then read-back, bypass path
        drive(1'b1, 1'b1, 3, pat_a, 8'hFF); step();
        drive(1'b1, 1'b0, 3, rand_word(), 8'h5A); step();
        drive(1'b0, 1'b0, 0, '0, '0);
        @(negedge clock);
        chkb("lit_a_valid", cl.resp_valid, 1'b1);
        chkd("lit_a_data", cl.resp_rdata, pat_a);
        step();

        // Lane-0-only write over pattern A
        drive(1'b1, 1'b1, 3, pat_b, 8'h01); step();
        drive(1'b1, 1'b0, 3, '0, '0); step();
        drive(1'b0, 1'b0, 0, '0, '0);
        exp_ab = pat_a;
        exp_ab[355:0] = pat_b[355:0];
        @(negedge clock);
        chkd("lit_mask_data", cl.resp_rdata, exp_ab);
        step();

        // Backpressure: two reads fit, third waits until the client drains
        d0 = ref_mem[0];
        d1 = ref_mem[1];
        cl.resp_ready = 1'b0;
        drive(1'b1, 1'b0, 0, '0, '0); step();
        drive(1'b1, 1'b0, 1, '0, '0); step();
        drive(1'b1, 1'b0, 2, '0, '0);
        @(negedge clock);
        chkb("lit_bp_stall", cl.req_ready, 1'b0);
        step();
        cl.resp_ready = 1'b1;
        @(negedge clock);
        chkb("lit_bp_still", cl.req_ready, 1'b0);
        chkd("lit_bp_first", cl.resp_rdata, d0);
        step();
        @(negedge clock);
        chkb("lit_bp_resume", cl.req_ready, 1'b1);
        chkd("lit_bp_second", cl.resp_rdata, d1);
        step();
        drive(1'b0, 1'b0, 0, '0, '0);
        step(); step();

        // Reset right after a read is accepted discards the response
        drive(1'b1, 1'b0, 5, '0, '0); step();
        drive(1'b0, 1'b0, 0, '0, '0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_init();
        step();
        d5 = ref_mem[5];
        drive(1'b1, 1'b0, 5, '0, '0); step();
        drive(1'b0, 1'b0, 0, '0, '0);
        @(negedge clock);
        chkd("lit_post_rst_read", cl.resp_rdata, d5);
`ifdef SRAM_INIT_SWEEP_EN
        chkd("lit_init_zero", cl.resp_rdata, '0);
`endif
        step();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cl.req_valid  = ($urandom_range(0, 3) != 0);
            cl.req_write  = ($urandom_range(0, 2) == 0);
            cl.req_addr   = ADDR_W'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
            cl.req_wdata  = rand_word();
            cl.req_wmask  = MASK_W'($urandom);
            cl.resp_ready = ($urandom_range(0, 3) != 0);
            reset         = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 0, '0, '0);
        cl.resp_ready = 1'b1;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
